priority_queue_kv: RTL

Parametrised key/payload priority queue: the next generation of the team's single-clock priority queue. It stores up to DEPTH entries in slot storage and presents the best entry through a combinational selection tree. It adds:
- a MIN/MAX mode;
- a payload carried alongside each key;
- a same-cycle REPLACE (pop-then-push);
- a synchronous flush;
- occupancy and status outputs;
- an error pulse for illegal requests.

It sits between a producer that pushes scheduled work and a consumer that drains it in priority order.

---
 rtl/priority_queue_kv_if.sv | 32 +++
 rtl/priority_queue_kv.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/priority_queue_kv_if.sv
// Request/response bundle between a producer/consumer pair and the key/payload priority queue.
// The master side issues operations and consumes the best entry; the slave side is the queue.
interface priority_queue_kv_if #(
  parameter int KEY_WIDTH     = 8,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int CNT_WIDTH     = 4
);
  logic                     flush;
  logic [1:0]               op;
  logic [KEY_WIDTH-1:0]     in_key;
  logic [PAYLOAD_WIDTH-1:0] in_payload;
  logic                     in_valid;
  logic                     in_ready;
  logic [KEY_WIDTH-1:0]     out_key;
  logic [PAYLOAD_WIDTH-1:0] out_payload;
  logic                     out_valid;
  logic                     out_ready;
  logic [CNT_WIDTH-1:0]     count;
  logic                     full;
  logic                     empty;
  logic                     op_error;

  modport master (
    output flush, op, in_key, in_payload, in_valid, out_ready,
    input  in_ready, out_key, out_payload, out_valid, count, full, empty, op_error
  );

  modport slave (
    input  flush, op, in_key, in_payload, in_valid, out_ready,
    output in_ready, out_key, out_payload, out_valid, count, full, empty, op_error
  );
endinterface

// File: rtl/priority_queue_kv.sv
// Slot-based key/payload priority queue: DEPTH slots feed a balanced comparator tree that
// presents the best valid entry (max or min key, lowest slot on ties) with one op per cycle.
module priority_queue_kv #(
  parameter int KEY_WIDTH     = 8,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int DEPTH         = 8,
  parameter int MODE_MIN      = 0,
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  priority_queue_kv_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LVLS  = $clog2(DEPTH);

  localparam logic [1:0] OP_PUSH    = 2'b01;
  localparam logic [1:0] OP_POP     = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [KEY_WIDTH-1:0]     key_q [DEPTH];
  logic [KEY_WIDTH-1:0]     key_d [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] pay_q [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] pay_d [DEPTH];
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     err_q, err_d;

  // Level 0 holds the slots; each higher level halves the node count until one winner remains.
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = DEPTH >> l;
    logic                 nv [N];
    logic [KEY_WIDTH-1:0] nk [N];
    logic [IDX_W-1:0]     ni [N];

    if (l == 0) begin : g_leaf
      for (genvar s = 0; s < N; s++) begin : g_s
        assign nv[s] = vld_q[s];
        assign nk[s] = key_q[s];
        assign ni[s] = IDX_W'(s);
      end
    end else begin : g_node
      for (genvar n = 0; n < N; n++) begin : g_n
        logic                 lv, rv, pick_r;
        logic [KEY_WIDTH-1:0] lk, rk;
        assign lv = g_lvl[l-1].nv[2*n];
        assign rv = g_lvl[l-1].nv[2*n+1];
        assign lk = g_lvl[l-1].nk[2*n];
        assign rk = g_lvl[l-1].nk[2*n+1];
        // Right child only wins strictly, so equal keys resolve to the lower slot index.
        assign pick_r = rv && (!lv || ((MODE_MIN != 0) ? (rk < lk) : (rk > lk)));
        assign nv[n]  = lv | rv;
        assign nk[n]  = pick_r ? rk : lk;
        assign ni[n]  = pick_r ? g_lvl[l-1].ni[2*n+1] : g_lvl[l-1].ni[2*n];
      end
    end
  end

  logic             best_v;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] free_idx;
  logic             full_w, empty_w;

  assign best_v   = g_lvl[LVLS].nv[0];
  assign best_idx = g_lvl[LVLS].ni[0];
  assign full_w   = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty_w  = (cnt_q == '0);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vld_q[i]) free_idx = IDX_W'(i);
    end
  end

  logic push_fire, pop_fire, rep_ovw, rep_push, rep_pop, do_push, do_pop, err_req;

  assign push_fire = (bus.op == OP_PUSH) && bus.in_valid && !full_w;
  assign pop_fire  = (bus.op == OP_POP) && best_v && bus.out_ready;
  assign rep_ovw   = (bus.op == OP_REPLACE) && bus.in_valid && best_v && bus.out_ready;
  assign rep_push  = (bus.op == OP_REPLACE) && bus.in_valid && !best_v;
  assign rep_pop   = (bus.op == OP_REPLACE) && !bus.in_valid && best_v && bus.out_ready;
  assign do_push   = push_fire | rep_push;
  assign do_pop    = pop_fire | rep_pop;
  assign err_req   = ((bus.op == OP_PUSH) && bus.in_valid && full_w) ||
                     ((bus.op == OP_POP) && bus.out_ready && empty_w);

  always_comb begin
    vld_d = vld_q;
    key_d = key_q;
    pay_d = pay_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (bus.flush) begin
      vld_d = '0;
      cnt_d = '0;
    end else begin
      err_d = err_req;
      if (do_push) begin
        vld_d[free_idx] = 1'b1;
        key_d[free_idx] = bus.in_key;
        pay_d[free_idx] = bus.in_payload;
        cnt_d           = cnt_q + CNT_WIDTH'(1);
      end else if (do_pop) begin
        vld_d[best_idx] = 1'b0;
        cnt_d           = cnt_q - CNT_WIDTH'(1);
      end else if (rep_ovw) begin
        key_d[best_idx] = bus.in_key;
        pay_d[best_idx] = bus.in_payload;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
        pay_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      key_q <= key_d;
      pay_q <= pay_d;
    end
  end

  assign bus.count       = cnt_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.in_ready    = !full_w;
  assign bus.out_valid   = best_v;
  assign bus.out_key     = best_v ? key_q[best_idx] : '0;
  assign bus.out_payload = best_v ? pay_q[best_idx] : '0;
  assign bus.op_error    = err_q;

endmodule
